// File: rtl/spi_slave.sv
// SPI responder: synchronised sclk/ss/mosi, all CPOL/CPHA modes, one-deep tx holding register.
// Define SPI_SLAVE_MISO_TRISTATE_EN to float miso while deselected or in reset.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic [1:0] stateout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sr, ss_sr, mosi_sr;
  logic       sclk_s, ss_s, mosi_s;
  logic       sclk_d, ss_d;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [7:0] rx_shift, tx_shift, hold;
  logic       hold_full;
  logic       rise, fall, lead, trail;
  logic       sample_e, shift_e, ss_fall, reload, drive;

  // ss chain clears low so a transfer in flight at reset
  // release never looks like a fresh falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr <= '0;
      ss_sr   <= '0;
      mosi_sr <= '0;
      sclk_d  <= 1'b0;
      ss_d    <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      ss_sr   <= {ss_sr[SYNC_STAGES-2:0], ss};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      sclk_d  <= sclk_s;
      ss_d    <= ss_s;
    end
  end

  assign sclk_s   = sclk_sr[SYNC_STAGES-1];
  assign ss_s     = ss_sr[SYNC_STAGES-1];
  assign mosi_s   = mosi_sr[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_d;
  assign fall     = ~sclk_s & sclk_d;
  assign lead     = cpol ? fall : rise;
  assign trail    = cpol ? rise : fall;
  assign sample_e = cpha ? trail : lead;
  assign shift_e  = cpha ? lead : trail;
  assign ss_fall  = ss_d & ~ss_s;

  // cpha=0 reloads on the shift edge after the 8th sample,
  // cpha=1 reloads on the 8th sample edge itself
  always_comb begin
    reload = 1'b0;
    if (!ss_s) begin
      if (state == LOAD)
        reload = 1'b1;
      else if (state == SHIFT)
        reload = cpha ? (sample_e && cnt == 3'd7)
                      : (shift_e && cnt == 3'd0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      rx_shift    <= 8'h00;
      tx_shift    <= 8'h00;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (ss_s) begin
        state    <= IDLE;
        cnt      <= 3'd0;
        rx_shift <= 8'h00;
        tx_shift <= 8'h00;
      end else begin
        case (state)
          IDLE: if (ss_fall) state <= LOAD;
          LOAD: state <= SHIFT;
          default: begin
            if (sample_e) begin
              rx_shift <= {rx_shift[6:0], mosi_s};
              cnt      <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                rx_data  <= {rx_shift[6:0], mosi_s};
                rx_valid <= 1'b1;
              end
            end
            if (shift_e && cnt != 3'd0)
              tx_shift <= {tx_shift[6:0], 1'b0};
          end
        endcase
        if (reload) begin
          tx_shift    <= hold_full ? hold : 8'h00;
          tx_underrun <= ~hold_full;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= 8'h00;
      hold_full <= 1'b0;
    end else if (tx_load) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (reload) begin
      hold_full <= 1'b0;
    end
  end

  assign drive    = ~reset & ~ss_s & (state != IDLE);
  assign busy     = ~ss_s & (state != IDLE);
  assign tx_ready = ~hold_full;
  assign stateout = state;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = drive ? tx_shift[7] : 1'bz;
`else
  assign miso = drive ? tx_shift[7] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bus-master model, rx scoreboard queue.
// Honours SPI_SLAVE_MISO_TRISTATE_EN for the idle miso level.
module tb_spi_slave;

  localparam int HALF = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       sclk = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic       tx_underrun;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic [1:0] stateout;

  int total = 0;
  int bad = 0;
  int rxv_cnt = 0;
  int und_cnt = 0;
  int und_at_rx = 0;
  logic [7:0] rxq[$];
  logic [7:0] got;
  logic       miso_idle;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
    .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy), .stateout(stateout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    chk("tx_ready_low", tx_ready, 0);
  endtask

  task automatic ss_low();
    ss = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_high();
    tick(HALF);
    ss = 1'b1;
    tick(HALF);
  endtask

  task automatic set_mode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    tick(HALF);
  endtask

  task automatic xfer(input logic [7:0] mo, input int nb,
                      output logic [7:0] rcv);
    rcv = 8'h00;
    for (int i = 0; i < nb; i++) begin
      if (!cpha) begin
        mosi = mo[7-i];
        tick(HALF);
        rcv[7-i] = miso;
        sclk = ~cpol;
        tick(HALF);
        sclk = cpol;
      end else begin
        sclk = ~cpol;
        mosi = mo[7-i];
        tick(HALF);
        rcv[7-i] = miso;
        sclk = cpol;
        tick(HALF);
      end
    end
    tick(HALF);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rxv_cnt++;
        und_at_rx = und_cnt;
        if (rxq.size() != 0) chk("rx_data", rx_data, rxq.pop_front());
        else chk("rx_unexpected", rx_valid, 0);
      end
      if (tx_underrun) und_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b0;
`endif
    tick(4);
    chk("rst_state", stateout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_miso", miso, miso_idle);
    reset = 1'b0;
    tick(8);

    // mode 0 basic exchange
    rxv_cnt = 0; und_cnt = 0; und_at_rx = 0;
    load(8'hA5);
    ss_low();
    chk("busy", busy, 1);
    rxq.push_back(8'h3C);
    xfer(8'h3C, 8, got);
    chk("m0_miso", got, 8'hA5);
    chk("m0_und", und_at_rx, 0);
    ss_high();
    chk("m0_rxv", rxv_cnt, 1);
    chk("m0_rxq", rxq.size(), 0);
    chk("idle_miso", miso, miso_idle);

    // all four modes
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0]);
      rxv_cnt = 0;
      load(8'h96);
      ss_low();
      rxq.push_back(8'h69);
      xfer(8'h69, 8, got);
      chk($sformatf("mode%0d_miso", m), got, 8'h96);
      ss_high();
      chk($sformatf("mode%0d_rxv", m), rxv_cnt, 1);
      chk($sformatf("mode%0d_rxq", m), rxq.size(), 0);
    end

    // back-to-back with refill
    set_mode(1'b0, 1'b0);
    rxv_cnt = 0;
    load(8'h11);
    ss_low();
    chk("b2b_ready", tx_ready, 1);
    load(8'h22);
    rxq.push_back(8'hA1);
    rxq.push_back(8'hA2);
    xfer(8'hA1, 8, got);
    chk("b2b_miso0", got, 8'h11);
    xfer(8'hA2, 8, got);
    chk("b2b_miso1", got, 8'h22);
    ss_high();
    chk("b2b_rxv", rxv_cnt, 2);

    // underrun on second byte
    rxv_cnt = 0; und_cnt = 0; und_at_rx = 0;
    load(8'h5A);
    ss_low();
    rxq.push_back(8'h01);
    rxq.push_back(8'h02);
    xfer(8'h01, 8, got);
    chk("und_miso0", got, 8'h5A);
    chk("und_before", und_at_rx, 0);
    chk("und_pulse", und_cnt, 1);
    xfer(8'h02, 8, got);
    chk("und_miso1", got, 8'h00);
    ss_high();
    chk("und_rxv", rxv_cnt, 2);

    // abort after 4 bits, then a full byte
    rxv_cnt = 0;
    load(8'h77);
    ss_low();
    xfer(8'hFF, 4, got);
    ss_high();
    chk("abort_rxv", rxv_cnt, 0);
    chk("abort_state", stateout, 0);
    load(8'hE7);
    ss_low();
    rxq.push_back(8'hC3);
    xfer(8'hC3, 8, got);
    chk("abort_miso", got, 8'hE7);
    ss_high();
    chk("abort_rxv2", rxv_cnt, 1);
    chk("abort_rxq", rxq.size(), 0);

    // reset mid-byte
    rxv_cnt = 0;
    load(8'h5A);
    ss_low();
    xfer(8'hF0, 3, got);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_state", stateout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rx_data", rx_data, 8'h00);
    chk("mrst_rx_valid", rx_valid, 0);
    chk("mrst_tx_ready", tx_ready, 1);
    chk("mrst_underrun", tx_underrun, 0);
    chk("mrst_miso", miso, miso_idle);
    tick(3);
    reset = 1'b0;
    xfer(8'h0F, 5, got);
    chk("mrst_ignored", rxv_cnt, 0);
    chk("mrst_idle", stateout, 0);
    ss_high();
    load(8'h3A);
    ss_low();
    rxq.push_back(8'h5C);
    xfer(8'h5C, 8, got);
    chk("mrst_miso2", got, 8'h3A);
    ss_high();
    chk("mrst_rxv", rxv_cnt, 1);
    chk("mrst_rxq", rxq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI responder (slave) for the SPI bus driven by the team's `spi_master`. It samples `sclk`, `ss` and `mosi` into the system clock domain and supports all four CPOL/CPHA modes. It shifts one byte MSB-first in each direction per 8 sclk cycles, and exchanges bytes with local logic through a one-deep transmit holding register and a receive output register with a valid strobe.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchroniser depth on `sclk`, `ss`, `mosi` (minimum 2).

Ports:
- `clk` input 1: system clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `cpol` input 1: sclk idle level; must be static while `ss` is low.
- `cpha` input 1: 0 = sample on leading edge, 1 = sample on trailing edge; must be static while `ss` is low.
- `sclk` input 1: bus clock from master, asynchronous.
- `ss` input 1: slave select, active low, asynchronous.
- `mosi` input 1: serial data from master.
- `miso` output 1: serial data to master.
- `tx_data` input 8: byte to transmit.
- `tx_load` input 1: write `tx_data` into the holding register.
- `tx_ready` output 1: holding register empty.
- `tx_underrun` output 1: one-cycle pulse when a byte starts with the holding register empty.
- `rx_data` output 8: last complete received byte.
- `rx_valid` output 1: one-cycle pulse when `rx_data` updates.
- `busy` output 1: high while `ss` (synchronised) is low.
- `stateout` output 2: current FSM state, for monitoring.

## Operation
- Front end: `sclk`, `ss` and `mosi` each pass through `SYNC_STAGES` flops. Edges are detected on the synchronised `sclk` by comparing it with a one-cycle-delayed copy.
- Edge classes:
  - Leading edge = transition away from `cpol`; trailing edge = transition back to `cpol`.
  - Sample edge = leading if `cpha`=0, trailing if `cpha`=1. Shift edge = the other one.
- FSM states:
  - IDLE (0): `ss` high. `sclk` edges are ignored; bit counter = 0.
  - LOAD (1): entered for one cycle on the synchronised `ss` falling edge. The shift register is loaded from the holding register, or 8'h00 if the holding register is empty. Go to SHIFT.
  - SHIFT (2): on each sample edge, `rx_shift <= {rx_shift[6:0], mosi_sync}` and the bit counter increments.
  - Exit from any state: synchronised `ss` high returns the FSM to IDLE.
- MISO generation: `miso` = `tx_shift[7]` whenever `ss` is low.
  - `cpha`=0: every shift edge performs `tx_shift <= tx_shift<<1`, except the shift edge after the 8th sample edge, which reloads the next byte instead.
  - `cpha`=1: the first shift edge of each byte does not shift. Later shift edges shift. The next byte is reloaded on the 8th sample edge.
- Byte completion (8th sample edge): `rx_data <= {rx_shift[6:0], mosi_sync}`, `rx_valid` pulses, and the bit counter wraps to 0.
- Holding register:
  - `tx_load` sets it full and captures `tx_data`. A load while already full overwrites the previous byte.
  - Every reload empties it. A reload that finds it empty sends 8'h00 and pulses `tx_underrun`.
  - `tx_load` in the same cycle as a reload: the reload takes the old content (or 8'h00), then the new byte is stored and the register is full.
- `ss` deasserted mid-byte: partial bits are discarded, with no `rx_valid` and no `tx_underrun`. The shift register is discarded; the holding register is kept.
- Reset mid-transfer: everything clears immediately. The remaining bus activity is ignored until the next `ss` falling edge.

## Timing
- Reset values:
  - `stateout`=0, `busy`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_ready`=1, `tx_underrun`=0.
  - `miso`=1'bz (or 0, see Configuration).
  - Internal registers: shift registers 0, bit counter 0, holding register empty.
- Pin-to-action latency is `SYNC_STAGES`+1 clk cycles. This applies from a pin transition to the corresponding shift, sample or FSM action.
- `rx_valid` asserts in the cycle the 8th sample edge is detected. `rx_data` is stable from that cycle until the next byte completes.
- `tx_ready` falls the cycle after `tx_load`. It rises the cycle after a reload.
- Bus constraint: the sclk half-period must be at least 2*(`SYNC_STAGES`+1)+2 clk cycles, i.e. 8 at default. The `spi_master` half-period of 16 clk satisfies this. `ss` falling must lead the first sclk edge by the same amount.

## Configuration
- `SPI_SLAVE_MISO_TRISTATE_EN` defined: `miso` = 1'bz whenever synchronised `ss` is high or `reset` is asserted, which allows a shared MISO bus.
- Not defined: `miso` drives 1'b0 in those conditions. All other behaviour is identical.

## Test plan
- Mode 0 (cpol=0, cpha=0): `tx_load` 8'hA5, master sends 8'h3C → `rx_data`=8'h3C with exactly one `rx_valid` pulse; master receives 8'hA5; `tx_underrun`=0.
- All four modes, `tx_data` 8'h96, master sends 8'h69 → slave gets 8'h69 and master gets 8'h96 in each mode.
- Back-to-back bytes, `ss` held low: load 8'h11, then reload 8'h22 while `tx_ready`=1 → master receives 8'h11, 8'h22; two `rx_valid` pulses.
- Underrun: second byte with no `tx_load` → master receives 8'h00; `tx_underrun` pulses once at the reload.
- Abort: `ss` raised after 4 sclk cycles → no `rx_valid`, FSM returns to IDLE; next full byte 8'hC3 is received correctly.
- Reset asserted mid-byte → outputs at reset values within the same cycle; `miso`=z with the macro defined, 0 without.
